// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: opcodes, flag bit positions, FSM states and iterative-unit modes shared by the ALU.
package alu_seq_pkg;
  localparam int OP_ADD  = 0;
  localparam int OP_SUB  = 1;
  localparam int OP_AND  = 2;
  localparam int OP_OR   = 3;
  localparam int OP_XOR  = 4;
  localparam int OP_NOT  = 5;
  localparam int OP_SHL  = 6;
  localparam int OP_SHR  = 7;
  localparam int OP_SAR  = 8;
  localparam int OP_MUL  = 9;
  localparam int OP_DIV  = 10;
  localparam int OP_CMP  = 11;
  localparam int OP_PASS = 12;
  localparam int FLAG_W  = 5;
  localparam int F_ZERO  = 0;
  localparam int F_CARRY = 1;
  localparam int F_OVF   = 2;
  localparam int F_NEG   = 3;
  localparam int F_DIV0  = 4;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  typedef enum logic {MODE_MUL, MODE_DIV} iter_mode_t;
  function automatic logic is_iter(input int op);
    return op == OP_MUL || op == OP_DIV;
  endfunction
endpackage

// File: rtl/alu_seq_iter_unit.sv
// alu_iter_unit: WIDTH-cycle shift-add multiplier / restoring divider.
// done is high during the final iteration; lo/hi then show the finished product or quotient/remainder.
module alu_iter_unit
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  iter_mode_t       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);
  localparam int CW = $clog2(WIDTH);
  iter_mode_t mode_q, mode_d;
  logic busy_q, busy_d, rge;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] lo_q, lo_d, hi_q, hi_d, md_q, md_d, rdif;
  logic [WIDTH:0] msum, rsh;
  always_comb begin
    msum = {1'b0, hi_q} + {1'b0, md_q & {WIDTH{lo_q[0]}}};
    rsh = {hi_q, lo_q[WIDTH-1]};
    rge = rsh >= {1'b0, md_q};
    rdif = rsh[WIDTH-1:0] - md_q;
    done = busy_q && cnt_q == CW'(WIDTH - 1);
    mode_d = mode_q;
    busy_d = busy_q;
    cnt_d = cnt_q;
    lo_d = lo_q;
    hi_d = hi_q;
    md_d = md_q;
    if (start) begin
      mode_d = mode;
      busy_d = 1'b1;
      cnt_d = '0;
      lo_d = a;
      hi_d = '0;
      md_d = b;
    end else if (busy_q) begin
      busy_d = !done;
      cnt_d = cnt_q + 1'b1;
      // a zero divisor always "fits", so the quotient saturates and the remainder collects a
      hi_d = mode_q == MODE_DIV ? (rge ? rdif : rsh[WIDTH-1:0]) : msum[WIDTH:1];
      lo_d = mode_q == MODE_DIV ? {lo_q[WIDTH-2:0], rge} : {msum[0], lo_q[WIDTH-1:1]};
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      mode_q <= MODE_MUL;
      busy_q <= 1'b0;
      cnt_q <= '0;
      lo_q <= '0;
      hi_q <= '0;
      md_q <= '0;
    end else begin
      mode_q <= mode_d;
      busy_q <= busy_d;
      cnt_q <= cnt_d;
      lo_q <= lo_d;
      hi_q <= hi_d;
      md_q <= md_d;
    end
  assign lo = lo_d;
  assign hi = hi_d;
endmodule

// File: rtl/alu_seq.sv
// alu_seq: valid/ready ALU with registered result, flags word and iterative multiply/divide.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 20,
  parameter int OP_W  = 4,
  parameter int SH_W  = $clog2(WIDTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   op,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  result,
  output logic [WIDTH-1:0]  result_hi,
  output logic [FLAG_W-1:0] flags
);
  state_t state_q, state_d;
  logic in_ready_q, in_ready_d, out_valid_q, out_valid_d, mul_q, mul_d, div0_q, div0_d;
  logic [WIDTH-1:0] result_q, result_d, result_hi_q, result_hi_d, alu_res, it_lo, it_hi;
  logic [FLAG_W-1:0] flags_q, flags_d, alu_flags;
  logic [WIDTH:0] add_s, sub_s;
  logic [SH_W-1:0] sh;
  logic alu_c, alu_v, add_v, sub_v, accept, it_done;
  int opi;
  assign opi = int'(op);
  assign accept = in_valid && in_ready_q;
  alu_iter_unit #(.WIDTH(WIDTH)) u_iter (
    .clk(clk),
    .rst(rst),
    .start(accept && is_iter(opi)),
    .mode(opi == OP_DIV ? MODE_DIV : MODE_MUL),
    .a(a),
    .b(b),
    .done(it_done),
    .lo(it_lo),
    .hi(it_hi)
  );
  always_comb begin
    sh = b[SH_W-1:0];
    add_s = {1'b0, a} + {1'b0, b};
    sub_s = {1'b0, a} - {1'b0, b};
    add_v = (a[WIDTH-1] == b[WIDTH-1]) && (add_s[WIDTH-1] != a[WIDTH-1]);
    sub_v = (a[WIDTH-1] != b[WIDTH-1]) && (sub_s[WIDTH-1] != a[WIDTH-1]);
    alu_res = '0;
    alu_c = 1'b0;
    alu_v = 1'b0;
    case (opi)
      OP_ADD: {alu_c, alu_v, alu_res} = {add_s[WIDTH], add_v, add_s[WIDTH-1:0]};
      OP_SUB: {alu_c, alu_v, alu_res} = {sub_s[WIDTH], sub_v, sub_s[WIDTH-1:0]};
      OP_AND: alu_res = a & b;
      OP_OR: alu_res = a | b;
      OP_XOR: alu_res = a ^ b;
      OP_NOT: alu_res = ~a;
      OP_SHL: alu_res = a << sh;
      OP_SHR: alu_res = a >> sh;
      OP_SAR: alu_res = $unsigned($signed(a) >>> sh);
      OP_PASS: alu_res = b;
      default: alu_res = '0;
    endcase
    // CMP reports subtraction flags but an equality-based zero; reserved opcodes report nothing
    alu_flags = opi == OP_CMP ? {1'b0, sub_s[WIDTH-1], sub_v, sub_s[WIDTH], a == b}
              : opi > OP_PASS ? '0
              : {1'b0, alu_res[WIDTH-1], alu_v, alu_c, alu_res == '0};
  end
  always_comb begin
    state_d = state_q;
    in_ready_d = in_ready_q;
    out_valid_d = out_valid_q;
    mul_d = mul_q;
    div0_d = div0_q;
    result_d = result_q;
    result_hi_d = result_hi_q;
    flags_d = flags_q;
    if (accept) begin
      in_ready_d = 1'b0;
      mul_d = opi == OP_MUL;
      div0_d = opi == OP_DIV && b == '0;
      state_d = is_iter(opi) ? BUSY : DONE;
      out_valid_d = !is_iter(opi);
      result_d = alu_res;
      result_hi_d = '0;
      flags_d = is_iter(opi) ? '0 : alu_flags;
    end else if (state_q == BUSY && it_done) begin
      state_d = DONE;
      out_valid_d = 1'b1;
      result_d = it_lo;
      result_hi_d = it_hi;
      flags_d = '0;
      flags_d[F_ZERO] = it_lo == '0;
      flags_d[F_CARRY] = mul_q && it_hi != '0;
      flags_d[F_NEG] = it_lo[WIDTH-1];
      flags_d[F_DIV0] = div0_q;
    end else if (state_q == DONE && out_ready) begin
      state_d = IDLE;
      out_valid_d = 1'b0;
      in_ready_d = 1'b1;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      in_ready_q <= 1'b1;
      out_valid_q <= 1'b0;
      mul_q <= 1'b0;
      div0_q <= 1'b0;
      result_q <= '0;
      result_hi_q <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      in_ready_q <= in_ready_d;
      out_valid_q <= out_valid_d;
      mul_q <= mul_d;
      div0_q <= div0_d;
      result_q <= result_d;
      result_hi_q <= result_hi_d;
      flags_q <= flags_d;
    end
  assign in_ready = in_ready_q;
  assign out_valid = out_valid_q;
  assign result = result_q;
  assign result_hi = result_hi_q;
  assign flags = flags_q;
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed and randomized checks of alu_seq against an arithmetic reference model.
module tb_alu_seq;
  localparam int W = 20;
  localparam longint M = 64'h100000;
  localparam longint H = 64'h80000;
  typedef struct {
    logic [W-1:0] res;
    logic [W-1:0] hi;
    logic [4:0]   fl;
    int           lat;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic in_ready, out_valid;
  logic [3:0] op_i = '0;
  logic [W-1:0] a_i = '0, b_i = '0, result, result_hi;
  logic [4:0] flags;
  int checks = 0;
  int failures = 0;
  alu_seq #(.WIDTH(W)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .op(op_i),
    .a(a_i),
    .b(b_i),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result(result),
    .result_hi(result_hi),
    .flags(flags)
  );
  always #5 clk = ~clk;
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic longint sv(input longint x);
    return x >= H ? x - M : x;
  endfunction
  function automatic bit inr(input longint x);
    return x >= -H && x < H;
  endfunction
  // {div0, neg, ovf, carry, zero} straight from the arithmetic definitions
  function automatic exp_t model(input int op, input longint a, input longint b);
    exp_t e;
    longint r, h, t, amt;
    bit c, v, d0;
    r = 0; h = 0; c = 0; v = 0; d0 = 0; e.lat = 1;
    amt = b % 32;
    case (op)
      0: begin t = a + b; r = t % M; c = t >= M; v = !inr(sv(a) + sv(b)); end
      1, 11: begin r = (a - b + M) % M; c = a < b; v = !inr(sv(a) - sv(b)); end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = M - 1 - a;
      6: r = amt >= W ? 0 : (a << amt) % M;
      7: r = a >> amt;
      8: r = (sv(a) >>> amt) & (M - 1);
      9: begin t = a * b; r = t % M; h = t / M; c = h != 0; e.lat = W + 1; end
      10: begin
        e.lat = W + 1;
        if (b == 0) begin r = M - 1; h = a; d0 = 1; end
        else begin r = a / b; h = a % b; end
      end
      12: r = b;
      default: r = 0;
    endcase
    e.res = (op == 11) ? '0 : W'(r);
    e.hi = W'(h);
    if (op == 11) e.fl = {1'b0, r >= H, v, c, a == b};
    else if (op > 12) e.fl = '0;
    else e.fl = {d0, r >= H, v, c, r == 0};
    return e;
  endfunction
  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 4))
      0: return '0;
      1: return {W{1'b1}};
      2: return W'(H);
      3: return W'($urandom_range(0, 25));
      default: return W'($urandom);
    endcase
  endfunction
  task automatic run(input int op, input logic [W-1:0] av, input logic [W-1:0] bv, input int hold);
    exp_t e;
    int n;
    bit ir_bad;
    e = model(op, longint'(av), longint'(bv));
    @(negedge clk);
    op_i = 4'(op); a_i = av; b_i = bv; in_valid = 1'b1;
    chk($sformatf("in_ready_idle op%0d", op), 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0; op_i = 4'($urandom); a_i = W'($urandom); b_i = W'($urandom);
    n = 1; ir_bad = 0;
    while (!out_valid && n < 60) begin
      ir_bad = ir_bad | in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    ir_bad = ir_bad | in_ready;
    chk($sformatf("latency op%0d", op), 64'(n), 64'(e.lat));
    chk($sformatf("result op%0d a=%0h b=%0h", op, av, bv), 64'(result), 64'(e.res));
    chk($sformatf("result_hi op%0d a=%0h b=%0h", op, av, bv), 64'(result_hi), 64'(e.hi));
    chk($sformatf("flags op%0d a=%0h b=%0h", op, av, bv), 64'(flags), 64'(e.fl));
    repeat (hold) begin
      @(posedge clk);
      #1;
      chk($sformatf("hold op%0d", op), 64'({out_valid, in_ready, result, result_hi, flags}),
          64'({1'b1, 1'b0, e.res, e.hi, e.fl}));
    end
    chk($sformatf("in_ready_low op%0d", op), 64'(ir_bad), 64'd0);
    @(negedge clk) out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk($sformatf("release op%0d", op), 64'({out_valid, in_ready}), 64'b01);
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_result", 64'(result), 64'd0);
    chk("rst_result_hi", 64'(result_hi), 64'd0);
    chk("rst_flags", 64'(flags), 64'd0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);
    run(0, 20'hFFFFF, 20'h00001, 0);
    run(1, 20'h80000, 20'h00001, 0);
    run(11, 20'd5, 20'd5, 0);
    run(9, 20'h000AA, 20'h00003, 0);
    run(9, 20'hFFFFF, 20'h00002, 1);
    run(10, 20'd100, 20'd7, 0);
    run(10, 20'h12345, 20'h00000, 0);
    run(6, 20'h00001, 20'd19, 5);
    run(8, 20'h80000, 20'd31, 0);
    run(14, 20'h12345, 20'h54321, 0);
    // abort a multiply mid-flight with an asynchronous reset
    @(negedge clk);
    op_i = 4'd9; a_i = 20'h12345; b_i = 20'h00777; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("abort_out_valid", 64'(out_valid), 64'd0);
    chk("abort_result", 64'(result), 64'd0);
    chk("abort_result_hi", 64'(result_hi), 64'd0);
    chk("abort_flags", 64'(flags), 64'd0);
    @(negedge clk) rst = 1'b0;
    run(0, 20'd2, 20'd3, 0);
    for (int i = 0; i < 40; i++) run(int'($urandom_range(0, 15)), pick(), pick(), int'($urandom_range(0, 2)));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
Parametrised, handshaked successor to the 20-bit combinational ALU in the CPU datapath. It adds registered outputs, a flags word, and iterative multiply/divide. It sits between the register-file read stage and writeback. Valid/ready on both sides lets the control FSM stall on multi-cycle ops.

Parameters:
WIDTH, 20, operand/result width in bits (>=4)
OP_W, 4, opcode width
SH_W, $clog2(WIDTH), shift-amount bits taken from B

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  operands/op presented
in_ready  output  1  block can accept an op
op  input  OP_W  operation select
a  input  WIDTH  operand A
b  input  WIDTH  operand B
out_valid  output  1  result/flags valid
out_ready  input  1  consumer takes result
result  output  WIDTH  low result word / quotient
result_hi  output  WIDTH  MUL high word / DIV remainder, else 0
flags  output  5  {div0, neg, ovf, carry, zero}

Behaviour:
- One clock; reset is asynchronous and active-high.
- Reset, asynchronous: state=IDLE, in_ready=1 once deasserted, out_valid=0, result=0, result_hi=0, flags=0. Reset mid-op aborts it and discards the partial result.
- States: IDLE, BUSY, DONE.
  - IDLE: in_ready=1. Accept on in_valid&in_ready. Single-cycle op -> DONE (out_valid high the cycle after accept, latency 1). MUL/DIV -> BUSY with iteration counter=0.
  - BUSY: one iteration per cycle for WIDTH cycles, then DONE. out_valid rises WIDTH+1 cycles after the accept edge.
  - DONE: out_valid=1, in_ready=0. Outputs held stable until out_valid&out_ready, then -> IDLE. No back-to-back accept in the same cycle.
- Opcodes (unsigned A, B):
  - 0 ADD: a+b. carry=carry-out. ovf=signed overflow.
  - 1 SUB: a-b. carry=borrow (a<b unsigned). ovf=signed overflow.
  - 2 AND, 3 OR, 4 XOR: carry=ovf=0.
  - 5 NOT a: carry=ovf=0.
  - 6 SHL, 7 SHR, 8 SAR: shift by b[SH_W-1:0]. Amount >=WIDTH gives 0 (SHL/SHR) or all sign bits (SAR). carry=ovf=0.
  - 9 MUL: shift-add, unsigned, 2*WIDTH product split {result_hi,result}. carry=(result_hi!=0).
  - 10 DIV: restoring, unsigned. result=quotient, result_hi=remainder. If b==0: result=all ones, result_hi=a, div0=1, still WIDTH+1 latency.
  - 11 CMP: as SUB but result=0, result_hi=0; only flags are meaningful, zero=(a==b).
  - 12 PASS: result=b.
  - 13-15: result=0, flags=0, latency 1.
- zero=(result==0), except CMP. neg=result[WIDTH-1]. div0=0 for all ops except DIV by zero.
- Operands are captured at accept; input changes during BUSY/DONE are ignored.

Decomposition:
- Shared include alu_defs.vh: opcode localparams (OP_ADD..OP_PASS), flag bit indices, state encodings.
- One sub-module, alu_iter_unit: shift-add multiplier / restoring divider with start, mode, done. It has WIDTH-cycle fixed latency and is owned by the top FSM.

Test Plan:
- ADD a=0xFFFFF b=0x00001 -> result=0x00000, zero=1, carry=1, ovf=0; out_valid exactly 1 cycle after accept.
- SUB a=0x80000 b=0x00001 -> result=0x7FFFF, ovf=1, carry=0, neg=0. CMP a=5 b=5 -> zero=1, result=0.
- MUL a=0x000AA b=0x00003 -> result=0x001FE, result_hi=0; MUL 0xFFFFF*0x00002 -> result=0xFFFFE, result_hi=0x00001, carry=1. out_valid 21 cycles after accept; in_ready=0 throughout.
- DIV a=100 b=7 -> result=14, result_hi=2. DIV a=0x12345 b=0 -> result=0xFFFFF, result_hi=0x12345, div0=1.
- Backpressure: SHL a=0x00001 b=19 -> result=0x80000, neg=1. Hold out_ready=0 for 5 cycles: outputs stable, in_ready=0. Pulse out_ready: IDLE next cycle. SAR a=0x80000 b=31 -> result=0xFFFFF.
- Assert rst at BUSY cycle 7 of a MUL -> out_valid=0, result=0, flags=0 immediately. After release, a new ADD 2+3 -> result=5 in 1 cycle.
